// File: rtl/reg_writeback.sv
// Register-file write-port driver: arbitrates ALU results against buffered load
// results, issues one registered write per cycle, and tracks which registers
// are still waiting for load data so decode can stall on them.
module reg_writeback #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_rd,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_rd,
    input  logic [XLEN-1:0]          alu_wd,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [4:0]               ld_rd,
    input  logic [XLEN-1:0]          ld_wd,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    input  logic [4:0]               rd_q,
    output logic                     rs1_busy,
    output logic                     rs2_busy,
    output logic                     rd_busy,
    output logic                     we,
    output logic [4:0]               rd,
    output logic [XLEN-1:0]          wd,
    output logic [$clog2(DEPTH):0]   ld_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Load-result FIFO state; pointers wrap naturally because DEPTH is a power of two.
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [CW-1:0]   count_next;
    logic [4:0]      rd_mem [DEPTH];
    logic [XLEN-1:0] wd_mem [DEPTH];

    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            alu_win;
    logic            win_valid;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_wd;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_wd;

    // Write-port output registers.
    logic            we_reg;
    logic [4:0]      rd_reg;
    logic [XLEN-1:0] wd_reg;

    // Per-register pending-load scoreboard.
    logic [31:0]     pending_reg;
    logic [31:0]     pending_next;

    assign fifo_full  = (count_reg == CW'(DEPTH));
    assign fifo_empty = (count_reg == '0);

    // The ALU is only held off when the FIFO is full, so the head can drain.
    assign ld_ready  = !RST && !fifo_full;
    assign alu_ready = !RST && !fifo_full;

    assign push    = ld_valid && ld_ready;
    assign alu_win = alu_valid && alu_ready;
    // Pop uses the registered occupancy, so an entry pushed this cycle cannot leave this cycle.
    assign pop     = !RST && !alu_win && !fifo_empty;

    // The head is read combinationally so it can win the slot in the same cycle it is at the front.
    assign head_rd = rd_mem[rd_ptr_reg];
    assign head_wd = wd_mem[rd_ptr_reg];

    assign win_valid = alu_win || pop;
    assign sel_rd    = alu_win ? alu_rd : head_rd;
    assign sel_wd    = alu_win ? alu_wd : head_wd;

    // Occupancy update: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // FIFO pointers and occupancy; reset discards any buffered entries.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge CLK) begin
        if (push) begin
            rd_mem[wr_ptr_reg] <= ld_rd;
            wd_mem[wr_ptr_reg] <= ld_wd;
        end
    end

    // Registered write port; x0 winners still consume the slot but never assert we.
    always_ff @(posedge CLK) begin
        if (RST) begin
            we_reg <= 1'b0;
            rd_reg <= '0;
            wd_reg <= '0;
        end else begin
            we_reg <= win_valid && (sel_rd != 5'd0);
            if (win_valid) begin
                rd_reg <= sel_rd;
                wd_reg <= sel_wd;
            end
        end
    end

    // Next pending vector per register: an issue sets the bit and beats a same-cycle clear.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_pending
            if (gi == 0) begin : g_zero
                assign pending_next[gi] = 1'b0;
            end else begin : g_reg
                assign pending_next[gi] =
                    (issue_valid && (issue_rd == 5'(gi))) ||
                    (pending_reg[gi] && !(pop && (head_rd == 5'(gi))));
            end
        end
    endgenerate

    // Scoreboard register; ALU writes deliberately leave it untouched.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    assign rs1_busy = pending_reg[rs1];
    assign rs2_busy = pending_reg[rs2];
    assign rd_busy  = pending_reg[rd_q];

    assign we       = we_reg;
    assign rd       = rd_reg;
    assign wd       = wd_reg;
    assign ld_count = count_reg;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: ALU vector table, scoreboard of expected register
// writes checked at every negedge, and hand-written multi-cycle sequences.
module tb_reg_writeback;

    logic        CLK;
    logic        RST;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_wd;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_wd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd_q;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_busy;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [2:0]  ld_count;

    reg_writeback #(.DEPTH(4), .XLEN(32)) dut (
        .CLK(CLK), .RST(RST),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_wd(ld_wd),
        .rs1(rs1), .rs2(rs2), .rd_q(rd_q),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
        .we(we), .rd(rd), .wd(wd), .ld_count(ld_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
    } wr_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        exp_we;
    } alu_vec_t;

    wr_t      exp_q[$];
    alu_vec_t vecs[5];
    int       n_cmp  = 0;
    int       n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
        wr_t e;
        e.rd = r;
        e.wd = d;
        exp_q.push_back(e);
    endtask

    // Every asserted write must match the next expected write, in order.
    always @(negedge CLK) begin
        if (!RST && we) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got rd=%0d wd=%0h required no write", rd, wd);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_rd", 32'(rd), 32'(e.rd));
                chk("wr_wd", wd, e.wd);
            end
        end
    end

    initial begin
        vecs[0] = '{rd: 5'd5,  wd: 32'h0000_1234, exp_we: 1'b1};
        vecs[1] = '{rd: 5'd31, wd: 32'hFFFF_FFFF, exp_we: 1'b1};
        vecs[2] = '{rd: 5'd1,  wd: 32'h0000_0000, exp_we: 1'b1};
        vecs[3] = '{rd: 5'd0,  wd: 32'h0000_ABCD, exp_we: 1'b0};
        vecs[4] = '{rd: 5'd17, wd: 32'h5A5A_5A5A, exp_we: 1'b1};

        RST = 1'b1;
        issue_valid = 1'b0; issue_rd = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_wd = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_wd = '0;
        rs1 = 5'd1; rs2 = 5'd2; rd_q = 5'd3;

        // Reset state
        tick; tick;
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_ld_count", 32'(ld_count), 32'd0);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_busy", {29'd0, rs1_busy, rs2_busy, rd_busy}, 32'd0);
        RST = 1'b0;
        #1;
        chk("ready_after_rst", {30'd0, alu_ready, ld_ready}, 32'd3);

        // ALU vector table: one-cycle latency, then we drops
        for (int i = 0; i < 5; i++) begin
            alu_valid = 1'b1;
            alu_rd = vecs[i].rd;
            alu_wd = vecs[i].wd;
            if (vecs[i].exp_we) expect_wr(vecs[i].rd, vecs[i].wd);
            tick;
            alu_valid = 1'b0;
            chk("alu_we", 32'(we), 32'(vecs[i].exp_we));
            chk("alu_rd", 32'(rd), 32'(vecs[i].rd));
            chk("alu_wd", wd, vecs[i].wd);
            tick;
            chk("alu_we_after", 32'(we), 32'd0);
        end

        // Single load: busy while pending, write two cycles after acceptance
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick;
        issue_valid = 1'b0;
        rs1 = 5'd7;
        #1;
        chk("ld7_busy_set", 32'(rs1_busy), 32'd1);
        ld_valid = 1'b1; ld_rd = 5'd7; ld_wd = 32'hDEAD;
        expect_wr(5'd7, 32'hDEAD);
        tick;
        ld_valid = 1'b0;
        chk("ld7_no_bypass_we", 32'(we), 32'd0);
        chk("ld7_count1", 32'(ld_count), 32'd1);
        chk("ld7_still_busy", 32'(rs1_busy), 32'd1);
        tick;
        chk("ld7_we", 32'(we), 32'd1);
        chk("ld7_rd", 32'(rd), 32'd7);
        chk("ld7_busy_clear", 32'(rs1_busy), 32'd0);
        chk("ld7_count0", 32'(ld_count), 32'd0);
        tick;
        chk("ld7_we_after", 32'(we), 32'd0);

        // ALU and load in the same cycle: ALU first
        issue_valid = 1'b1; issue_rd = 5'd4;
        tick;
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_wd = 32'h33;
        ld_valid = 1'b1; ld_rd = 5'd4; ld_wd = 32'h44;
        expect_wr(5'd3, 32'h33);
        expect_wr(5'd4, 32'h44);
        rd_q = 5'd4;
        tick;
        alu_valid = 1'b0; ld_valid = 1'b0;
        chk("both_rd_first", 32'(rd), 32'd3);
        chk("both_count1", 32'(ld_count), 32'd1);
        chk("both_rd4_busy", 32'(rd_busy), 32'd1);
        tick;
        chk("both_rd_second", 32'(rd), 32'd4);
        chk("both_count0", 32'(ld_count), 32'd0);
        chk("both_rd4_clear", 32'(rd_busy), 32'd0);
        tick;

        // FIFO fill with continuous ALU traffic, starvation guard, in-order drain
        for (int k = 0; k < 4; k++) begin
            issue_valid = 1'b1; issue_rd = 5'(10 + k);
            tick;
        end
        issue_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(20 + k); alu_wd = 32'hA000 + 32'(k);
            ld_valid = 1'b1; ld_rd = 5'(10 + k); ld_wd = 32'hB000 + 32'(k);
            #1;
            chk("fill_alu_ready", 32'(alu_ready), 32'd1);
            chk("fill_ld_ready", 32'(ld_ready), 32'd1);
            expect_wr(5'(20 + k), 32'hA000 + 32'(k));
            tick;
        end
        ld_valid = 1'b0;
        alu_rd = 5'd24; alu_wd = 32'hA004;
        #1;
        chk("full_count", 32'(ld_count), 32'd4);
        chk("full_ld_ready", 32'(ld_ready), 32'd0);
        chk("full_alu_ready", 32'(alu_ready), 32'd0);
        expect_wr(5'd10, 32'hB000);
        rd_q = 5'd10; rs1 = 5'd11;
        tick;
        chk("drain_count3", 32'(ld_count), 32'd3);
        chk("drain_alu_ready", 32'(alu_ready), 32'd1);
        chk("drain_rd10_clear", 32'(rd_busy), 32'd0);
        chk("drain_rs11_busy", 32'(rs1_busy), 32'd1);
        expect_wr(5'd24, 32'hA004);
        tick;
        alu_valid = 1'b0;
        expect_wr(5'd11, 32'hB001);
        expect_wr(5'd12, 32'hB002);
        expect_wr(5'd13, 32'hB003);
        tick; tick; tick;
        chk("drain_count0", 32'(ld_count), 32'd0);
        rs1 = 5'd11; rs2 = 5'd12; rd_q = 5'd13;
        #1;
        chk("drain_busy_clear", {29'd0, rs1_busy, rs2_busy, rd_busy}, 32'd0);
        tick;
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        // x0 destinations: no write, no pending bit
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick;
        issue_valid = 1'b0;
        rs1 = 5'd0;
        #1;
        chk("x0_busy", 32'(rs1_busy), 32'd0);
        ld_valid = 1'b1; ld_rd = 5'd0; ld_wd = 32'hBEEF;
        tick;
        ld_valid = 1'b0;
        chk("x0_count1", 32'(ld_count), 32'd1);
        tick;
        chk("x0_ld_we", 32'(we), 32'd0);
        chk("x0_ld_wd", wd, 32'hBEEF);
        chk("x0_count0", 32'(ld_count), 32'd0);
        tick;

        // Same-register set and clear in one cycle: set wins
        issue_valid = 1'b1; issue_rd = 5'd6;
        tick;
        issue_valid = 1'b0;
        ld_valid = 1'b1; ld_rd = 5'd6; ld_wd = 32'h66;
        expect_wr(5'd6, 32'h66);
        tick;
        ld_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd6;
        tick;
        issue_valid = 1'b0;
        rs1 = 5'd6;
        #1;
        chk("setwins_busy", 32'(rs1_busy), 32'd1);
        ld_valid = 1'b1; ld_rd = 5'd6; ld_wd = 32'h67;
        expect_wr(5'd6, 32'h67);
        tick;
        ld_valid = 1'b0;
        tick;
        chk("setwins_cleared", 32'(rs1_busy), 32'd0);
        tick;

        // Reset with three buffered loads and pending bits
        for (int k = 0; k < 3; k++) begin
            issue_valid = 1'b1; issue_rd = 5'(1 + k);
            tick;
        end
        issue_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = '0;
            ld_valid = 1'b1; ld_rd = 5'(1 + k); ld_wd = 32'hC000 + 32'(k);
            tick;
        end
        ld_valid = 1'b0;
        alu_rd = 5'd9; alu_wd = 32'h99;
        rs1 = 5'd1; rs2 = 5'd2; rd_q = 5'd3;
        #1;
        chk("prerst_count3", 32'(ld_count), 32'd3);
        chk("prerst_busy", {29'd0, rs1_busy, rs2_busy, rd_busy}, 32'd7);
        RST = 1'b1;
        #1;
        chk("inrst_ready", {30'd0, alu_ready, ld_ready}, 32'd0);
        tick;
        RST = 1'b0;
        alu_valid = 1'b0;
        #1;
        chk("postrst_count", 32'(ld_count), 32'd0);
        chk("postrst_busy", {29'd0, rs1_busy, rs2_busy, rd_busy}, 32'd0);
        chk("postrst_we", 32'(we), 32'd0);
        for (int k = 0; k < 5; k++) tick;
        chk("postrst_no_stale", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
